// File: rtl/wb_stream_burst_writer_if.sv
// Stream input and Wishbone master signals of the burst writer, bundled as one port.
// master = the writer; slave = the stream source plus the Wishbone slave side.
interface wb_stream_burst_writer_if #(
    parameter int AW = 26,
    parameter int DW = 32
);
    logic            s_valid;
    logic [DW-1:0]   s_data;
    logic            s_ready;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_addr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_ack_i;

    modport master (
        input  s_valid, s_data, wb_ack_i,
        output s_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
    );

    modport slave (
        output s_valid, s_data, wb_ack_i,
        input  s_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
    );
endinterface

// File: rtl/wb_stream_burst_writer.sv
// Buffers a valid/ready word stream in a FIFO and writes it to consecutive
// addresses as Wishbone incrementing bursts of up to BURST_LEN beats.
module wb_stream_burst_writer #(
    parameter int AW         = 26,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_LEN  = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start,
    input  logic [AW-1:0] cfg_base_addr,
    input  logic [15:0]   cfg_word_cnt,
    output logic          busy,
    output logic          done,
    wb_stream_burst_writer_if.master bus
);
    localparam int SW = DW / 8;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {IDLE, FILL, BURST, DONE} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fifo_count;
    logic [15:0]   rx_rem, tx_rem, burst_n;
    logic [BW-1:0] beat_cnt;
    logic [AW-1:0] addr;
    logic [2:0]    cti;
    logic          fifo_full, fill_ok, push, pop, last_beat, in_burst, accept_start;

    assign in_burst     = (state == BURST);
    assign busy         = (state == FILL) || in_burst;
    assign done         = (state == DONE);
    assign accept_start = (state == IDLE) && start;

    assign fifo_full = (fifo_count == (PW+1)'(FIFO_DEPTH));
    assign burst_n   = (tx_rem < 16'(BURST_LEN)) ? tx_rem : 16'(BURST_LEN);
    assign fill_ok   = (16'(fifo_count) >= burst_n);
    assign push      = bus.s_valid && bus.s_ready;
    assign pop       = in_burst && bus.wb_ack_i;
    assign last_beat = pop && (beat_cnt == BW'(1));

    // Full flag is taken before any same-cycle pop: no bypass into a full FIFO.
    assign bus.s_ready   = busy && !fifo_full && (rx_rem != '0);
    assign bus.wb_cyc_o  = in_burst;
    assign bus.wb_stb_o  = in_burst;
    assign bus.wb_we_o   = 1'b1;
    assign bus.wb_addr_o = addr;
    assign bus.wb_dat_o  = mem[rd_ptr];
    assign bus.wb_sel_o  = in_burst ? '1 : '0;
    assign bus.wb_cti_o  = cti;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = (cfg_word_cnt != '0) ? FILL : DONE;
            FILL:  if (fill_ok) state_nx = BURST;
            BURST: if (last_beat) state_nx = (tx_rem != 16'd1) ? FILL : DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= bus.s_data;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rx_rem     <= '0;
            tx_rem     <= '0;
            beat_cnt   <= '0;
            addr       <= '0;
            cti        <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (accept_start)  rx_rem <= cfg_word_cnt;
            else if (push)     rx_rem <= rx_rem - 16'd1;

            if (accept_start)  tx_rem <= cfg_word_cnt;
            else if (pop)      tx_rem <= tx_rem - 16'd1;

            if (accept_start)  addr <= cfg_base_addr & ~AW'(SW - 1);
            else if (pop)      addr <= addr + AW'(SW);

            // cti is registered one beat ahead so 111 coincides with the final beat.
            if (state == FILL && fill_ok) begin
                beat_cnt <= burst_n[BW-1:0];
                cti      <= (burst_n == 16'd1) ? 3'b111 : 3'b010;
            end else if (pop) begin
                beat_cnt <= beat_cnt - BW'(1);
                if (beat_cnt == BW'(1))      cti <= 3'b000;
                else if (beat_cnt == BW'(2)) cti <= 3'b111;
                else                         cti <= 3'b010;
            end
        end
    end
endmodule

// File: tb/tb_wb_stream_burst_writer.sv
// Directed bench for wb_stream_burst_writer: stream source, delayed-ack Wishbone
// slave with a beat log, and one task per scenario with inline expectations.
module tb_wb_stream_burst_writer;
    localparam int AW = 26;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, start, busy, done;
    logic [AW-1:0] cfg_base;
    logic [15:0]   cfg_cnt;

    wb_stream_burst_writer_if #(.AW(AW), .DW(DW)) bus ();

    wb_stream_burst_writer #(.AW(AW), .DW(DW), .FIFO_DEPTH(16), .BURST_LEN(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .cfg_base_addr(cfg_base),
        .cfg_word_cnt(cfg_cnt), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int ack_delay = 0;
    int wait_cnt  = 0;
    assign bus.wb_ack_i = bus.wb_cyc_o && bus.wb_stb_o && (wait_cnt >= ack_delay);
    always @(posedge clk) begin
        if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i) wait_cnt <= wait_cnt + 1;
        else                                                wait_cnt <= 0;
    end

    logic [AW-1:0] b_addr[$];
    logic [DW-1:0] b_data[$];
    logic [2:0]    b_cti[$];
    int            b_stamp[$];
    int            burst_len[$];
    int            done_stamp[$];
    logic [DW-1:0] sdram [logic [AW-1:0]];
    int  cyc_no = 0, cur_len = 0, cyc_cycles = 0;
    int  sel_bad = 0, ready_bad = 0, max_occ = 0, pushed = 0, popped = 0;
    bit  prev_cyc = 0, push_pending = 0, mon_en = 0;

    // Monitor: samples at negedge, logs what the next posedge will transfer.
    initial begin
        forever begin
            @(negedge clk);
            cyc_no++;
            push_pending = bus.s_valid && bus.s_ready && !rst;
            if (mon_en) begin
                if (bus.wb_stb_o ? (bus.wb_sel_o !== 4'hF) : (bus.wb_sel_o !== 4'h0)) sel_bad++;
                if ((pushed - popped) == 16 && bus.s_ready) ready_bad++;
                if ((pushed - popped) > max_occ) max_occ = pushed - popped;
                if (bus.wb_cyc_o) cyc_cycles++;
                if (done) done_stamp.push_back(cyc_no);
                if (rst) begin
                    pushed = 0;
                    popped = 0;
                end else begin
                    if (push_pending) pushed++;
                    if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i) begin
                        popped++;
                        cur_len++;
                        b_addr.push_back(bus.wb_addr_o);
                        b_data.push_back(bus.wb_dat_o);
                        b_cti.push_back(bus.wb_cti_o);
                        b_stamp.push_back(cyc_no);
                        sdram[bus.wb_addr_o] = bus.wb_dat_o;
                    end
                end
                if (prev_cyc && !bus.wb_cyc_o) begin
                    burst_len.push_back(cur_len);
                    cur_len = 0;
                end
                prev_cyc = bus.wb_cyc_o;
            end
        end
    end

    logic [DW-1:0] words [64];
    int src_idx = 0, src_len = 0, period = 1, tick = 0;
    int b0 = 0, bl0 = 0, d0 = 0;

    // Advance one clock and drive the stream source at posedge+1.
    task automatic step();
        bit held;
        @(posedge clk);
        #1;
        held = bus.s_valid && !push_pending;
        if (push_pending) src_idx++;
        tick++;
        if (src_idx < src_len && (held || (tick % period) == 0)) begin
            bus.s_valid = 1'b1;
            bus.s_data  = words[src_idx];
        end else begin
            bus.s_valid = 1'b0;
            bus.s_data  = '0;
        end
    endtask

    task automatic begin_job(input logic [AW-1:0] base, input int cnt, input int per,
                             input int dly, input int job);
        for (int i = 0; i < 64; i++) words[i] = (32'(job) << 24) | 32'(i);
        src_idx   = 0;
        src_len   = cnt;
        period    = per;
        ack_delay = dly;
        cfg_base  = base;
        cfg_cnt   = 16'(cnt);
        b0  = b_addr.size();
        bl0 = burst_len.size();
        d0  = done_stamp.size();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_stamp.size() == d0 && n < limit) begin
            step();
            n++;
        end
        total++;
        if (done_stamp.size() == d0) begin
            bad++;
            $display("FAIL wait_done: no done pulse within %0d cycles", limit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        total += 10;
        if (busy !== 1'b0)             begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        if (done !== 1'b0)             begin bad++; $display("FAIL reset done: got %b want 0", done); end
        if (bus.s_ready !== 1'b0)      begin bad++; $display("FAIL reset s_ready: got %b want 0", bus.s_ready); end
        if (bus.wb_cyc_o !== 1'b0)     begin bad++; $display("FAIL reset cyc: got %b want 0", bus.wb_cyc_o); end
        if (bus.wb_stb_o !== 1'b0)     begin bad++; $display("FAIL reset stb: got %b want 0", bus.wb_stb_o); end
        if (bus.wb_cti_o !== 3'b000)   begin bad++; $display("FAIL reset cti: got %b want 000", bus.wb_cti_o); end
        if (bus.wb_addr_o !== 26'h0)   begin bad++; $display("FAIL reset addr: got %h want 0", bus.wb_addr_o); end
        if (bus.wb_sel_o !== 4'h0)     begin bad++; $display("FAIL reset sel: got %h want 0", bus.wb_sel_o); end
        if (bus.wb_we_o !== 1'b1)      begin bad++; $display("FAIL reset we: got %b want 1", bus.wb_we_o); end
        if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset idle: busy=%b done=%b want 0/0", busy, done); end
        mon_en = 1'b1;
    endtask

    task automatic test_word_boundary();
        int nb;
        begin_job(26'h100, 8, 1, 0, 0);
        wait_done(200);
        nb = b_addr.size() - b0;
        total++;
        if (nb != 8) begin bad++; $display("FAIL wb8 beats: got %0d want 8", nb); end
        for (int i = 0; i < 8 && i < nb; i++) begin
            total += 4;
            if (b_addr[b0+i] !== AW'(32'h100 + 4*i)) begin bad++; $display("FAIL wb8 addr[%0d]: got %h want %h", i, b_addr[b0+i], 32'h100 + 4*i); end
            if (b_data[b0+i] !== 32'(i)) begin bad++; $display("FAIL wb8 data[%0d]: got %h want %h", i, b_data[b0+i], i); end
            if (b_cti[b0+i] !== ((i == 7) ? 3'b111 : 3'b010)) begin bad++; $display("FAIL wb8 cti[%0d]: got %b", i, b_cti[b0+i]); end
            if (i > 0 && b_stamp[b0+i] != b_stamp[b0+i-1] + 1) begin bad++; $display("FAIL wb8 bubble[%0d]: got gap %0d want 1", i, b_stamp[b0+i] - b_stamp[b0+i-1]); end
        end
        total += 2;
        if (burst_len.size() - bl0 != 1 || burst_len[bl0] != 8) begin bad++; $display("FAIL wb8 bursts: got %0d bursts want one of 8", burst_len.size() - bl0); end
        if (nb == 8 && done_stamp.size() > d0 && done_stamp[d0] != b_stamp[b0+7] + 1) begin
            bad++; $display("FAIL wb8 done_latency: got %0d want 1", done_stamp[d0] - b_stamp[b0+7]);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (!sdram.exists(AW'(32'h100 + 4*i)) || sdram[AW'(32'h100 + 4*i)] !== 32'(i)) begin
                bad++; $display("FAIL wb8 readback[%0d]: word missing or wrong, want %h", i, i);
            end
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL wb8 busy_after: got %b want 0", busy); end
    endtask

    task automatic test_partial_burst();
        int nb;
        begin_job(26'h100, 19, 1, 0, 1);
        wait_done(400);
        nb = b_addr.size() - b0;
        total++;
        if (nb != 19) begin bad++; $display("FAIL p19 beats: got %0d want 19", nb); end
        for (int i = 0; i < 19 && i < nb; i++) begin
            total += 3;
            if (b_addr[b0+i] !== AW'(32'h100 + 4*i)) begin bad++; $display("FAIL p19 addr[%0d]: got %h want %h", i, b_addr[b0+i], 32'h100 + 4*i); end
            if (b_data[b0+i] !== ((32'd1 << 24) | 32'(i))) begin bad++; $display("FAIL p19 data[%0d]: got %h", i, b_data[b0+i]); end
            if (b_cti[b0+i] !== ((i == 7 || i == 15 || i == 18) ? 3'b111 : 3'b010)) begin bad++; $display("FAIL p19 cti[%0d]: got %b", i, b_cti[b0+i]); end
        end
        total++;
        if (burst_len.size() - bl0 != 3) begin
            bad++; $display("FAIL p19 burst_count: got %0d want 3", burst_len.size() - bl0);
        end else begin
            total += 3;
            if (burst_len[bl0]   != 8) begin bad++; $display("FAIL p19 burst0: got %0d want 8", burst_len[bl0]); end
            if (burst_len[bl0+1] != 8) begin bad++; $display("FAIL p19 burst1: got %0d want 8", burst_len[bl0+1]); end
            if (burst_len[bl0+2] != 3) begin bad++; $display("FAIL p19 burst2: got %0d want 3", burst_len[bl0+2]); end
        end
        total++;
        if (nb > 0 && b_addr[b_addr.size()-1] !== 26'h148) begin bad++; $display("FAIL p19 final_addr: got %h want 148", b_addr[b_addr.size()-1]); end
    endtask

    task automatic test_zero_and_busy();
        int c0, dz, nb;
        c0 = cyc_cycles;
        dz = done_stamp.size();
        cfg_base = 26'h500;
        cfg_cnt  = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        total += 3;
        if (done !== 1'b1) begin bad++; $display("FAIL zero done: got %b want 1", done); end
        if (busy !== 1'b0) begin bad++; $display("FAIL zero busy: got %b want 0", busy); end
        if (bus.wb_cyc_o !== 1'b0) begin bad++; $display("FAIL zero cyc: got %b want 0", bus.wb_cyc_o); end
        step();
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL zero done_width: got %b want 0", done); end
        repeat (4) step();
        total += 2;
        if (cyc_cycles != c0) begin bad++; $display("FAIL zero cyc_activity: got %0d cyc cycles want 0", cyc_cycles - c0); end
        if (done_stamp.size() - dz != 1) begin bad++; $display("FAIL zero done_count: got %0d want 1", done_stamp.size() - dz); end

        begin_job(26'h200, 4, 3, 0, 2);
        step();
        step();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy busy_flag: got %b want 1", busy); end
        cfg_base = 26'h0;
        cfg_cnt  = 16'd50;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(400);
        repeat (6) step();
        nb = b_addr.size() - b0;
        total += 2;
        if (nb != 4) begin bad++; $display("FAIL busy beats: got %0d want 4", nb); end
        if (done_stamp.size() - d0 != 1) begin bad++; $display("FAIL busy done_count: got %0d want 1", done_stamp.size() - d0); end
        for (int i = 0; i < 4 && i < nb; i++) begin
            total += 2;
            if (b_addr[b0+i] !== AW'(32'h200 + 4*i)) begin bad++; $display("FAIL busy addr[%0d]: got %h want %h", i, b_addr[b0+i], 32'h200 + 4*i); end
            if (b_data[b0+i] !== ((32'd2 << 24) | 32'(i))) begin bad++; $display("FAIL busy data[%0d]: got %h", i, b_data[b0+i]); end
        end
    endtask

    task automatic test_back_pressure();
        int nb;
        begin_job(26'h1000, 40, 1, 5, 3);
        wait_done(3000);
        nb = b_addr.size() - b0;
        total++;
        if (nb != 40) begin bad++; $display("FAIL bp beats: got %0d want 40", nb); end
        for (int i = 0; i < 40 && i < nb; i++) begin
            total += 2;
            if (b_addr[b0+i] !== AW'(32'h1000 + 4*i)) begin bad++; $display("FAIL bp addr[%0d]: got %h want %h", i, b_addr[b0+i], 32'h1000 + 4*i); end
            if (b_data[b0+i] !== ((32'd3 << 24) | 32'(i))) begin bad++; $display("FAIL bp data[%0d]: got %h want %h", i, b_data[b0+i], (32'd3 << 24) | 32'(i)); end
        end
        total += 3;
        if (max_occ != 16) begin bad++; $display("FAIL bp fifo_peak: got %0d want 16", max_occ); end
        if (ready_bad != 0) begin bad++; $display("FAIL bp ready_when_full: got %0d cycles want 0", ready_bad); end
        if (sel_bad != 0) begin bad++; $display("FAIL bp sel_vs_stb: got %0d bad cycles want 0", sel_bad); end
    endtask

    task automatic test_slow_and_wrap();
        int nb;
        begin_job(26'h400, 1, 3, 0, 4);
        wait_done(200);
        nb = b_addr.size() - b0;
        total++;
        if (nb != 1) begin
            bad++; $display("FAIL slow beats: got %0d want 1", nb);
        end else begin
            total += 3;
            if (b_addr[b0] !== 26'h400) begin bad++; $display("FAIL slow addr: got %h want 400", b_addr[b0]); end
            if (b_cti[b0] !== 3'b111) begin bad++; $display("FAIL slow cti: got %b want 111", b_cti[b0]); end
            if (b_data[b0] !== 32'h0400_0000) begin bad++; $display("FAIL slow data: got %h want 04000000", b_data[b0]); end
        end

        begin_job(26'h3FF_FFFC, 2, 3, 0, 5);
        wait_done(200);
        nb = b_addr.size() - b0;
        total++;
        if (nb != 2) begin
            bad++; $display("FAIL wrap beats: got %0d want 2", nb);
        end else begin
            total += 5;
            if (b_addr[b0]   !== 26'h3FF_FFFC) begin bad++; $display("FAIL wrap addr0: got %h want 3fffffc", b_addr[b0]); end
            if (b_addr[b0+1] !== 26'h0)        begin bad++; $display("FAIL wrap addr1: got %h want 0", b_addr[b0+1]); end
            if (b_cti[b0]    !== 3'b010)       begin bad++; $display("FAIL wrap cti0: got %b want 010", b_cti[b0]); end
            if (b_cti[b0+1]  !== 3'b111)       begin bad++; $display("FAIL wrap cti1: got %b want 111", b_cti[b0+1]); end
            if (b_data[b0+1] !== 32'h0500_0001) begin bad++; $display("FAIL wrap data1: got %h want 05000001", b_data[b0+1]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0, nb;
        begin_job(26'h800, 8, 1, 0, 6);
        while (b_addr.size() - b0 < 2 && n < 300) begin
            step();
            n++;
        end
        total += 2;
        if (b_addr.size() - b0 < 2) begin bad++; $display("FAIL rmid reach_beat3: got %0d beats want 2", b_addr.size() - b0); end
        if (bus.wb_stb_o !== 1'b1 || bus.wb_addr_o !== 26'h808) begin
            bad++; $display("FAIL rmid beat3_pending: stb=%b addr=%h want 1/808", bus.wb_stb_o, bus.wb_addr_o);
        end
        rst = 1'b1;
        src_len = src_idx;
        step();
        total += 6;
        if (bus.wb_cyc_o !== 1'b0)   begin bad++; $display("FAIL rmid cyc: got %b want 0", bus.wb_cyc_o); end
        if (bus.wb_stb_o !== 1'b0)   begin bad++; $display("FAIL rmid stb: got %b want 0", bus.wb_stb_o); end
        if (busy !== 1'b0)           begin bad++; $display("FAIL rmid busy: got %b want 0", busy); end
        if (bus.s_ready !== 1'b0)    begin bad++; $display("FAIL rmid s_ready: got %b want 0", bus.s_ready); end
        if (bus.wb_cti_o !== 3'b000) begin bad++; $display("FAIL rmid cti: got %b want 000", bus.wb_cti_o); end
        if (b_addr.size() - b0 != 2) begin bad++; $display("FAIL rmid beats_done: got %0d want 2", b_addr.size() - b0); end
        rst = 1'b0;
        step();

        begin_job(26'h300, 5, 1, 0, 7);
        wait_done(300);
        nb = b_addr.size() - b0;
        total++;
        if (nb != 5) begin bad++; $display("FAIL rnew beats: got %0d want 5", nb); end
        for (int i = 0; i < 5 && i < nb; i++) begin
            total += 3;
            if (b_addr[b0+i] !== AW'(32'h300 + 4*i)) begin bad++; $display("FAIL rnew addr[%0d]: got %h want %h", i, b_addr[b0+i], 32'h300 + 4*i); end
            if (b_data[b0+i] !== ((32'd7 << 24) | 32'(i))) begin bad++; $display("FAIL rnew data[%0d]: got %h want %h", i, b_data[b0+i], (32'd7 << 24) | 32'(i)); end
            if (b_cti[b0+i] !== ((i == 4) ? 3'b111 : 3'b010)) begin bad++; $display("FAIL rnew cti[%0d]: got %b", i, b_cti[b0+i]); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        cfg_base    = '0;
        cfg_cnt     = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        test_reset();
        test_word_boundary();
        test_partial_burst();
        test_zero_and_busy();
        test_back_pressure();
        test_slow_and_wrap();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
